execute: RTL and testbench

EXECUTE -- requirements
Module: execute

---
 rtl/execute.sv | 194 +++++++++++++++++++
 tb/tb_execute.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/execute.sv
// ============================================================================
// Module   : execute
// Brief    : Pipeline EX stage. Holds the ALU, an iterative radix-2
//            multiply/divide unit that owns the HI/LO registers, the
//            MF/MT HI/LO moves and the EX/MEM pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_e,
    input  logic [2:0]  control_e_i,
    input  logic [2:0]  alu_control_e,
    input  logic        alu_src_e,
    input  logic [31:0] src_a_e,
    input  logic [31:0] src_b_e,
    input  logic [31:0] sign_imm_e,
    input  logic [3:0]  md_op_e,
    input  logic [4:0]  write_reg_e,
    output logic        stall_e,
    output logic [2:0]  control_m_o,
    output logic [31:0] alu_result_m,
    output logic [31:0] mem_write_data_m,
    output logic [4:0]  write_reg_m
);

    // md_op_e encodings; 9..15 decode to nothing
    localparam logic [3:0] C_MD_MULT  = 4'd1;
    localparam logic [3:0] C_MD_MULTU = 4'd2;
    localparam logic [3:0] C_MD_DIV   = 4'd3;
    localparam logic [3:0] C_MD_DIVU  = 4'd4;
    localparam logic [3:0] C_MD_MFHI  = 4'd5;
    localparam logic [3:0] C_MD_MFLO  = 4'd6;
    localparam logic [3:0] C_MD_MTHI  = 4'd7;
    localparam logic [3:0] C_MD_MTLO  = 4'd8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [63:0] acc_q;        // {partial product | remainder, multiplier | dividend/quotient}
    logic [31:0] bmag_q;       // |B|: multiplicand or divisor
    logic [31:0] dividend_q;   // original dividend, returned in HI on divide-by-zero
    logic        is_div_q;
    logic        neg_q_q;      // negate product / quotient at the end
    logic        neg_r_q;      // negate remainder at the end
    logic        div_zero_q;

    logic [63:0] acc_d;
    logic [31:0] hi_fin_d, lo_fin_d;
    logic [31:0] alu_b, alu_res;
    logic        is_start_op, is_md_op, md_start, exec_e;
    logic        start_signed, start_div;
    logic [31:0] abs_a, abs_b;

    // Decode of the md operation and the stall/start conditions
    always_comb begin
        is_start_op  = (md_op_e >= C_MD_MULT) && (md_op_e <= C_MD_DIVU);
        is_md_op     = (md_op_e >= C_MD_MULT) && (md_op_e <= C_MD_MTLO);
        stall_e      = valid_e && is_md_op && (state_q == S_BUSY);
        exec_e       = valid_e && !stall_e;
        md_start     = valid_e && is_start_op && (state_q == S_IDLE);
        start_signed = (md_op_e == C_MD_MULT) || (md_op_e == C_MD_DIV);
        start_div    = (md_op_e == C_MD_DIV) || (md_op_e == C_MD_DIVU);
        abs_a        = (start_signed && src_a_e[31]) ? (32'd0 - src_a_e) : src_a_e;
        abs_b        = (start_signed && src_b_e[31]) ? (32'd0 - src_b_e) : src_b_e;
    end

    // ALU: operand select and operation
    always_comb begin
        alu_b = alu_src_e ? sign_imm_e : src_b_e;
        case (alu_control_e)
            3'b000:  alu_res = src_a_e & alu_b;
            3'b001:  alu_res = src_a_e | alu_b;
            3'b010:  alu_res = src_a_e + alu_b;
            3'b011:  alu_res = src_a_e ^ alu_b;
            3'b100:  alu_res = ~(src_a_e | alu_b);
            3'b101:  alu_res = {31'd0, (src_a_e < alu_b)};
            3'b110:  alu_res = src_a_e - alu_b;
            default: alu_res = {31'd0, ($signed(src_a_e) < $signed(alu_b))};
        endcase
    end

    // One radix-2 step of the md unit and the sign-corrected final HI/LO
    always_comb begin
        logic [32:0] sum;
        logic [33:0] diff;
        logic [32:0] shifted;
        logic [63:0] prod;
        logic [31:0] quot, rem;
        sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, bmag_q} : 33'd0);
        shifted = {acc_q[63:31]};
        diff    = {1'b0, shifted} - {2'b00, bmag_q};
        if (is_div_q) begin
            // restoring divide: keep the difference only when it did not borrow
            acc_d = {(diff[33] ? shifted[31:0] : diff[31:0]), acc_q[30:0], ~diff[33]};
        end else begin
            acc_d = {sum, acc_q[31:1]};
        end
        prod = neg_q_q ? (64'd0 - acc_d) : acc_d;
        quot = neg_q_q ? (32'd0 - acc_d[31:0]) : acc_d[31:0];
        rem  = neg_r_q ? (32'd0 - acc_d[63:32]) : acc_d[63:32];
        if (!is_div_q) begin
            hi_fin_d = prod[63:32];
            lo_fin_d = prod[31:0];
        end else if (div_zero_q) begin
            hi_fin_d = dividend_q;
            lo_fin_d = 32'hFFFF_FFFF;
        end else begin
            hi_fin_d = rem;
            lo_fin_d = quot;
        end
    end

    // md unit FSM, iteration datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            acc_q      <= 64'd0;
            bmag_q     <= 32'd0;
            dividend_q <= 32'd0;
            is_div_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (md_start) begin
                        state_q    <= S_BUSY;
                        cnt_q      <= 5'd31;
                        acc_q      <= {32'd0, abs_a};
                        bmag_q     <= abs_b;
                        dividend_q <= src_a_e;
                        is_div_q   <= start_div;
                        neg_q_q    <= start_signed && (src_a_e[31] ^ src_b_e[31]);
                        neg_r_q    <= start_signed && src_a_e[31];
                        div_zero_q <= (src_b_e == 32'd0);
                    end else if (exec_e && (md_op_e == C_MD_MTHI)) begin
                        hi_q <= src_a_e;
                    end else if (exec_e && (md_op_e == C_MD_MTLO)) begin
                        lo_q <= src_a_e;
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_d;
                    if (cnt_q == 5'd0) begin
                        hi_q    <= hi_fin_d;
                        lo_q    <= lo_fin_d;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // EX/MEM pipeline register; a stall inserts a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            control_m_o      <= 3'd0;
            alu_result_m     <= 32'd0;
            mem_write_data_m <= 32'd0;
            write_reg_m      <= 5'd0;
        end else if (stall_e) begin
            control_m_o <= 3'd0;
        end else begin
            control_m_o      <= valid_e ? control_e_i : 3'd0;
            mem_write_data_m <= src_b_e;
            write_reg_m      <= write_reg_e;
            if (valid_e && (md_op_e == C_MD_MFHI)) begin
                alu_result_m <= hi_q;
            end else if (valid_e && (md_op_e == C_MD_MFLO)) begin
                alu_result_m <= lo_q;
            end else begin
                alu_result_m <= alu_res;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_execute.sv
// ============================================================================
// Module   : tb_execute
// Brief    : Scoreboard bench for the execute stage. Stimulus pushes the
//            expected EX/MEM contents; a monitor pops on every register write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_e = 1'b0;
    logic [2:0]  control_e_i = 3'd0;
    logic [2:0]  alu_control_e = 3'd0;
    logic        alu_src_e = 1'b0;
    logic [31:0] src_a_e = 32'd0, src_b_e = 32'd0, sign_imm_e = 32'd0;
    logic [3:0]  md_op_e = 4'd0;
    logic [4:0]  write_reg_e = 5'd0;
    logic        stall_e;
    logic [2:0]  control_m_o;
    logic [31:0] alu_result_m, mem_write_data_m;
    logic [4:0]  write_reg_m;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] res;
        logic [31:0] wdata;
        logic [4:0]  wreg;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [2:0] RW   = 3'b100;
    localparam logic [2:0] RWS  = 3'b110;
    localparam logic [2:0] NONE = 3'b000;

    execute dut (
        .clk              (clk),
        .reset            (reset),
        .valid_e          (valid_e),
        .control_e_i      (control_e_i),
        .alu_control_e    (alu_control_e),
        .alu_src_e        (alu_src_e),
        .src_a_e          (src_a_e),
        .src_b_e          (src_b_e),
        .sign_imm_e       (sign_imm_e),
        .md_op_e          (md_op_e),
        .write_reg_e      (write_reg_e),
        .stall_e          (stall_e),
        .control_m_o      (control_m_o),
        .alu_result_m     (alu_result_m),
        .mem_write_data_m (mem_write_data_m),
        .write_reg_m      (write_reg_m)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every register-writing EX/MEM entry is compared with the oldest expectation
    always @(negedge clk) begin
        if (!reset && control_m_o[2]) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got result %h with empty scoreboard", alu_result_m);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", alu_result_m, e.res);
                check("wdata", mem_write_data_m, e.wdata);
                check("wreg", {27'd0, write_reg_m}, {27'd0, e.wreg});
                check("ctrl", {29'd0, control_m_o}, {29'd0, e.ctrl});
            end
        end
    end

    // Present one instruction, holding it while stalled; count and check stall cycles
    task automatic issue(input logic [2:0] ctrl, input logic [2:0] aluc, input logic asrc,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [3:0] md, input logic [4:0] wr,
                         input logic [31:0] exp_res, input int exp_stall);
        int stalls;
        logic s;
        valid_e = 1'b1; control_e_i = ctrl; alu_control_e = aluc; alu_src_e = asrc;
        src_a_e = a; src_b_e = b; sign_imm_e = imm; md_op_e = md; write_reg_e = wr;
        if (ctrl[2]) sb.push_back('{ctrl: ctrl, res: exp_res, wdata: b, wreg: wr});
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            #1 s = stall_e;
            @(posedge clk); #1;
            if (!s) break;
            stalls++;
            check("bubble_ctrl", {29'd0, control_m_o}, 32'd0);
        end
        check("stall_cycles", stalls, exp_stall);
        valid_e = 1'b0;
    endtask

    task automatic bubble(input int n);
        valid_e = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {29'd0, control_m_o}, 32'd0);
        check("rst_res", alu_result_m, 32'd0);
        check("rst_wdata", mem_write_data_m, 32'd0);
        check("rst_wreg", {27'd0, write_reg_m}, 32'd0);
        check("rst_stall", {31'd0, stall_e}, 32'd0);
        reset = 1'b0;
        bubble(1);

        // ALU vectors
        issue(RW,  3'b010, 1'b1, 32'h7FFF_FFFF, 32'h0000_0055, 32'h1, 4'd0, 5'd1, 32'h8000_0000, 0);
        issue(RW,  3'b111, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'd0, 5'd2, 32'h1, 0);
        issue(RW,  3'b101, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'd0, 5'd3, 32'h0, 0);
        issue(RWS, 3'b000, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 4'd0, 5'd4, 32'h00F0_1200, 0);
        issue(RW,  3'b001, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 4'd0, 5'd5, 32'hFFF0_FF34, 0);
        issue(RW,  3'b011, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 4'd0, 5'd6, 32'hFF00_ED34, 0);
        issue(RW,  3'b100, 1'b0, 32'h0000_FFFF, 32'h00FF_0000, 32'h0, 4'd0, 5'd7, 32'hFF00_0000, 0);
        issue(RW,  3'b110, 1'b0, 32'h0, 32'h1, 32'h0, 4'd0, 5'd8, 32'hFFFF_FFFF, 0);
        bubble(1);

        // MULT(-2, 3) then MFLO stalls for the whole operation
        issue(NONE, 3'b000, 1'b0, 32'hFFFF_FFFE, 32'h3, 32'h0, 4'd1, 5'd0, 32'h0, 0);
        issue(RW,   3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd6, 5'd9, 32'hFFFF_FFFA, 32);
        issue(RW,   3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd5, 5'd10, 32'hFFFF_FFFF, 0);

        // MULTU with independent ADDs flowing underneath
        issue(NONE, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'd2, 5'd0, 32'h0, 0);
        for (int i = 1; i <= 5; i++)
            issue(RW, 3'b010, 1'b0, 32'(i * 16), 32'(i), 32'h0, 4'd0, 5'(i), 32'(i * 17), 0);
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd5, 5'd11, 32'hFFFF_FFFE, 27);
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd6, 5'd12, 32'h0000_0001, 0);

        // DIV(-7, 2)
        issue(NONE, 3'b000, 1'b0, 32'hFFFF_FFF9, 32'h2, 32'h0, 4'd3, 5'd0, 32'h0, 0);
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd6, 5'd13, 32'hFFFF_FFFD, 32);
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd5, 5'd14, 32'hFFFF_FFFF, 0);

        // DIVU(7, 0)
        issue(NONE, 3'b000, 1'b0, 32'h7, 32'h0, 32'h0, 4'd4, 5'd0, 32'h0, 0);
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd6, 5'd15, 32'hFFFF_FFFF, 32);
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd5, 5'd16, 32'h0000_0007, 0);

        // DIV(-5, 0): signed divide-by-zero keeps the raw dividend in HI
        issue(NONE, 3'b000, 1'b0, 32'hFFFF_FFFB, 32'h0, 32'h0, 4'd3, 5'd0, 32'h0, 0);
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd6, 5'd17, 32'hFFFF_FFFF, 32);
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd5, 5'd18, 32'hFFFF_FFFB, 0);

        // DIV(0x80000000, -1)
        issue(NONE, 3'b000, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 4'd3, 5'd0, 32'h0, 0);
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd6, 5'd19, 32'h8000_0000, 32);
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd5, 5'd20, 32'h0000_0000, 0);

        // MTHI / MTLO followed by reads
        issue(NONE, 3'b000, 1'b0, 32'h1234_5678, 32'h0, 32'h0, 4'd7, 5'd0, 32'h0, 0);
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd5, 5'd21, 32'h1234_5678, 0);
        issue(NONE, 3'b000, 1'b0, 32'hCAFE_F00D, 32'h0, 32'h0, 4'd8, 5'd0, 32'h0, 0);
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd6, 5'd22, 32'hCAFE_F00D, 0);

        // DIVU(100, 3) aborted by reset at T+10
        issue(NONE, 3'b000, 1'b0, 32'd100, 32'd3, 32'h0, 4'd4, 5'd0, 32'h0, 0);
        bubble(9);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd5, 5'd23, 32'h0, 0);
        issue(RW, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 4'd6, 5'd24, 32'h0, 0);

        bubble(3);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
